projection_matrix_seq: RTL and testbench
========================================

// Module: projection_matrix_seq
// PURPOSE
//  Sequential, parametrised perspective-projection matrix generator. Takes inv_tan, aspect_ratio,
//  z_near, z_far in signed Qi.f and produces the 4x4 row-major matrix P:
//  P[0]=inv_tan/aspect, P[5]=inv_tan, P[10]=(nz+fz)*k, P[11]=2*nz*fz*k, P[14]=1.0, rest 0,
//  with nz=-z_near, fz=-z_far and k=1/(nz-fz).
//  One shared multiplier and one shared radix-2 divider; valid/ready on both sides.
//  Sits between the camera-parameter registers and the MVP matrix multiplier.
// PARAMETERS
//  WI  8  integer bits, sign included, of all inputs, outputs and internal values
//  WF  8  fraction bits; W=WI+WF; DIV_BITS=W+WF; LAT=2*DIV_BITS+4
// PORTS
//  clk                in   1         clock; all logic on the rising edge
//  rst_n              in   1         synchronous reset, active low
//  in_valid           in   1         operand set valid
//  in_ready           out  1         block can accept operands
//  inv_tan            in   W         1/tan(fov/2), signed Qi.f
//  aspect_ratio       in   W         signed Qi.f
//  z_near, z_far      in   W         signed Qi.f
//  out_valid          out  1         matrix and flags valid
//  out_ready          in   1         consumer accepts the matrix
//  projection_matrix  out  [15:0][W] registered result; element n at index n
//  div_zero           out  1         a divisor was 0 in this computation
//  overflow           out  1         any saturation occurred in this computation
// BEHAVIOUR
//  Reset (rst_n=0 at an edge): state=IDLE, in_ready=1, out_valid=0, matrix all 0, flags 0.
//   Reset overrides any state, including mid-divide. The aborted computation is discarded with no output.
//  FSM: IDLE -> DIVK -> MUL1 -> MUL2 -> MUL3 -> DIVA -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&&in_ready: latch operands, clear flags, go to DIVK. in_ready=0 from
//   the next cycle until the DONE handshake.
//   Register nz=-z_near and fz=-z_far, saturated so that -MIN -> MAX.
//  DIVK: DIV_BITS cycles. k=ONE/(nz-fz), where ONE=1<<WF and the subtract is saturated.
//  MUL1: tmp=nz*fz.  MUL2: P10=sat(nz+fz)*k.  MUL3: P11=sat(2*(tmp*k)). One cycle each.
//  DIVA: DIV_BITS cycles. P0=inv_tan/aspect_ratio.
//  DONE: write the full matrix. P5=inv_tan, P14=ONE, others 0. out_valid=1.
//   Hold the matrix and flags stable while out_ready=0.
//   On out_valid&&out_ready: out_valid=0 and in_ready=1 next cycle.
//   The matrix register keeps its last value.
//  Latency: out_valid rises exactly LAT edges after the accepting edge, independent of data.
//  Multiply: full 2W signed product. Round half-up: add 2^(WF-1), then arithmetic shift right WF.
//   Then saturate to [MIN,MAX]=[-2^(W-1), 2^(W-1)-1] and set overflow if clipped.
//  Divide: magnitudes, restoring, 1 quotient bit/cycle.
//   Dividend |a|<<WF (DIV_BITS bits), truncate toward zero.
//   Apply the sign as sign(a) XOR sign(b). Saturate to MAX/MIN and set overflow if clipped.
//  Divisor==0: still takes DIV_BITS cycles. Result is MAX if the dividend is >=0, else MIN.
//   Sets div_zero=1 and overflow=1. Downstream products use the saturated value.
//  Add/sub and doubling: saturating; set overflow on clip.
//  Flags are sticky within one computation, cleared on accept, valid with out_valid.
//  in_valid while busy is ignored; the operands are not latched.
// TESTING (WI=8, WF=8, LAT=52)
//  inv=0100, asp=0100, zn=0100, zf=0300
//   -> after 52 cycles P0=0100, P5=0100, P10=FE00, P11=0300, P14=0100, others 0000, flags 0
//  inv=0100, asp=FE00 (-2.0), zn=0100, zf=0300 -> P0=FF80; other elements as the first case
//  zn=zf=0200 -> div_zero=1, overflow=1, P10=8000
//  zn=6400 (100), zf=7800 (120) -> overflow=1, k=000C, P10=FA00
//  out_ready=0 for 10 cycles after out_valid -> matrix and flags stable, in_ready=0;
//   handshake -> in_ready=1 on the next cycle, out_valid=0
//  rst_n=0 for 1 cycle mid-DIVK -> next cycle out_valid=0, in_ready=1, matrix 0;
//   new operands accepted and correct after 52 cycles

Source files
------------

// File: rtl/projection_matrix_seq.sv
// projection_matrix_seq
//   Sequential perspective-projection matrix generator. Produces the 4x4
//   row-major matrix
//     P[0]  = inv_tan / aspect_ratio     P[5]  = inv_tan
//     P[10] = (nz + fz) * k              P[11] = 2 * nz * fz * k
//     P[14] = 1.0                        all other elements 0
//   with nz = -z_near, fz = -z_far, k = 1 / (nz - fz), all in signed Qi.f.
//   One shared multiplier and one shared restoring divider are time-multiplexed
//   by the FSM: IDLE -> DIVK -> MUL1 -> MUL2 -> MUL3 -> DIVA -> DONE -> IDLE.
//   Latency from the accepting edge to out_valid is 2*DIV_BITS+4 edges.
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   in_valid / in_ready     operand handshake
//   inv_tan, aspect_ratio,
//   z_near, z_far           operands, signed Qi.f, W bits
//   out_valid / out_ready   result handshake
//   projection_matrix       registered result, element n at index n
//   div_zero, overflow      sticky per-computation flags, valid with out_valid
module projection_matrix_seq #(
    parameter int WI = 8,
    parameter int WF = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WI+WF-1:0]             inv_tan,
    input  logic [WI+WF-1:0]             aspect_ratio,
    input  logic [WI+WF-1:0]             z_near,
    input  logic [WI+WF-1:0]             z_far,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [15:0][WI+WF-1:0]       projection_matrix,
    output logic                         div_zero,
    output logic                         overflow
);
    localparam int W        = WI + WF;
    localparam int DIV_BITS = W + WF;
    localparam int CW       = $clog2(DIV_BITS);

    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] ONE  = W'(1 << WF);

    typedef enum logic [2:0] {IDLE, DIVK, MUL1, MUL2, MUL3, DIVA, DONE} state_t;

    // All helpers return {clip_flag, value}.
    function automatic logic [W:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) return {1'b1, s[W] ? MINV : MAXV};
        return {1'b0, s[W-1:0]};
    endfunction

    function automatic logic [W:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {a[W-1], a} - {b[W-1], b};
        if (s[W] != s[W-1]) return {1'b1, s[W] ? MINV : MAXV};
        return {1'b0, s[W-1:0]};
    endfunction

    // Full product, round half-up, arithmetic shift, saturate.
    function automatic logic [W:0] sat_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [2*W-1:0] p;
        p = $signed(a) * $signed(b);
        p = p + (2*W)'(1 << (WF-1));
        p = p >>> WF;
        if (p[2*W-1:W-1] == '0 || p[2*W-1:W-1] == '1) return {1'b0, p[W-1:0]};
        return {1'b1, p[2*W-1] ? MINV : MAXV};
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] a);
        return a[W-1] ? (~a + 1'b1) : a;
    endfunction

    // Sign and saturate the unsigned quotient; divide-by-zero picks the
    // rail matching the dividend's sign.
    function automatic logic [W:0] div_fin(input logic [DIV_BITS-1:0] q, input logic neg,
                                           input logic dz, input logic aneg);
        logic [W-1:0] nq;
        if (dz) return {1'b1, aneg ? MINV : MAXV};
        if (!neg) begin
            if (q > DIV_BITS'(MAXV)) return {1'b1, MAXV};
            return {1'b0, q[W-1:0]};
        end
        if (q > DIV_BITS'(MINV)) return {1'b1, MINV};
        nq = '0 - q[W-1:0];
        return {1'b0, nq};
    endfunction

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [W-1:0]      nz, fz, inv_r, asp_r, k, tmp, p0, p10, p11;

    logic [W-1:0]          div_rem, div_den;
    logic [DIV_BITS-1:0]   div_quo;
    logic                  div_neg, div_dz, div_aneg;

    logic [W:0]            nz_s, fz_s, dk_s, sum_s, tmp_s, p10_s, m11_s, p11_s, q_s;
    logic [W:0]            rem_sh;
    logic                  ge, last;
    logic [DIV_BITS-1:0]   quo_nx;
    logic [W-1:0]          ld_a, ld_b;
    logic [15:0][W-1:0]    mat_nx;

    assign in_ready = (state == IDLE);
    assign last     = (cnt == CW'(DIV_BITS - 1));

    always_comb begin
        nz_s  = sat_sub('0, z_near);
        fz_s  = sat_sub('0, z_far);
        dk_s  = sat_sub(nz_s[W-1:0], fz_s[W-1:0]);
        sum_s = sat_add(nz, fz);
        tmp_s = sat_mul(nz, fz);
        p10_s = sat_mul(sum_s[W-1:0], k);
        m11_s = sat_mul(tmp, k);
        p11_s = sat_add(m11_s[W-1:0], m11_s[W-1:0]);

        // One restoring step: shift in the next dividend bit, subtract if it fits.
        rem_sh = {div_rem, div_quo[DIV_BITS-1]};
        ge     = (rem_sh >= {1'b0, div_den});
        quo_nx = {div_quo[DIV_BITS-2:0], ge};
        q_s    = div_fin(quo_nx, div_neg, div_dz, div_aneg);

        // Divider operands: k is loaded while accepting, P0 when leaving MUL3.
        ld_a = (state == IDLE) ? ONE : inv_r;
        ld_b = (state == IDLE) ? dk_s[W-1:0] : asp_r;

        mat_nx     = '0;
        mat_nx[0]  = p0;
        mat_nx[5]  = inv_r;
        mat_nx[10] = p10;
        mat_nx[11] = p11;
        mat_nx[14] = ONE;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (in_valid) state_nx = DIVK;
            DIVK: if (last) state_nx = MUL1;
            MUL1: state_nx = MUL2;
            MUL2: state_nx = MUL3;
            MUL3: state_nx = DIVA;
            DIVA: if (last) state_nx = DONE;
            DONE: if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt               <= '0;
            nz                <= '0;
            fz                <= '0;
            inv_r             <= '0;
            asp_r             <= '0;
            k                 <= '0;
            tmp               <= '0;
            p0                <= '0;
            p10               <= '0;
            p11               <= '0;
            div_rem           <= '0;
            div_den           <= '0;
            div_quo           <= '0;
            div_neg           <= 1'b0;
            div_dz            <= 1'b0;
            div_aneg          <= 1'b0;
            out_valid         <= 1'b0;
            projection_matrix <= '0;
            div_zero          <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            // Divider load is shared by IDLE (for k) and MUL3 (for P0).
            if ((state == IDLE && in_valid) || state == MUL3) begin
                div_rem  <= '0;
                div_quo  <= {mag(ld_a), {WF{1'b0}}};
                div_den  <= mag(ld_b);
                div_neg  <= ld_a[W-1] ^ ld_b[W-1];
                div_aneg <= ld_a[W-1];
                div_dz   <= (ld_b == '0);
                cnt      <= '0;
            end
            if (state == DIVK || state == DIVA) begin
                div_rem <= W'(ge ? rem_sh - {1'b0, div_den} : rem_sh);
                div_quo <= quo_nx;
                cnt     <= cnt + 1'b1;
            end

            case (state)
                IDLE: if (in_valid) begin
                    inv_r    <= inv_tan;
                    asp_r    <= aspect_ratio;
                    nz       <= nz_s[W-1:0];
                    fz       <= fz_s[W-1:0];
                    div_zero <= 1'b0;
                    overflow <= nz_s[W] | fz_s[W] | dk_s[W];
                end
                DIVK: if (last) begin
                    k        <= q_s[W-1:0];
                    overflow <= overflow | q_s[W];
                    div_zero <= div_zero | div_dz;
                end
                MUL1: begin
                    tmp      <= tmp_s[W-1:0];
                    overflow <= overflow | tmp_s[W];
                end
                MUL2: begin
                    p10      <= p10_s[W-1:0];
                    overflow <= overflow | sum_s[W] | p10_s[W];
                end
                MUL3: begin
                    p11      <= p11_s[W-1:0];
                    overflow <= overflow | m11_s[W] | p11_s[W];
                end
                DIVA: if (last) begin
                    p0       <= q_s[W-1:0];
                    overflow <= overflow | q_s[W];
                    div_zero <= div_zero | div_dz;
                end
                DONE: begin
                    // First DONE cycle publishes; afterwards hold until taken.
                    if (!out_valid) begin
                        projection_matrix <= mat_nx;
                        out_valid         <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_projection_matrix_seq.sv
module tb_projection_matrix_seq;
    logic              clk = 1'b0;
    logic              rst_n, in_valid, out_ready;
    logic              in_ready, out_valid, div_zero, overflow;
    logic [15:0]       inv_tan, aspect_ratio, z_near, z_far;
    logic [15:0][15:0] projection_matrix;

    projection_matrix_seq #(.WI(8), .WF(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .inv_tan(inv_tan), .aspect_ratio(aspect_ratio), .z_near(z_near), .z_far(z_far),
        .out_valid(out_valid), .out_ready(out_ready),
        .projection_matrix(projection_matrix), .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on real-valued Q8.8 numbers.
    bit                m_ovf, m_dz;
    logic [15:0][15:0] exp_mat;

    function automatic longint clip(input longint x);
        if (x > 32767)  begin m_ovf = 1; return 32767;  end
        if (x < -32768) begin m_ovf = 1; return -32768; end
        return x;
    endfunction

    function automatic longint qmul(input longint a, input longint b);
        return clip((a * b + 128) >>> 8);
    endfunction

    function automatic longint qdiv(input longint a, input longint b);
        longint q;
        if (b == 0) begin
            m_dz = 1; m_ovf = 1;
            return (a >= 0) ? 32767 : -32768;
        end
        q = ((a < 0 ? -a : a) * 256) / (b < 0 ? -b : b);
        return clip(((a < 0) != (b < 0)) ? -q : q);
    endfunction

    task automatic model(input logic [15:0] iv, asp, zn, zf);
        longint nz, fz, k, tmp, p0, p10, p11;
        m_ovf = 0; m_dz = 0;
        nz  = clip(-longint'($signed(zn)));
        fz  = clip(-longint'($signed(zf)));
        k   = qdiv(256, clip(nz - fz));
        tmp = qmul(nz, fz);
        p10 = qmul(clip(nz + fz), k);
        p11 = clip(2 * qmul(tmp, k));
        p0  = qdiv(longint'($signed(iv)), longint'($signed(asp)));
        exp_mat     = '0;
        exp_mat[0]  = p0[15:0];
        exp_mat[5]  = iv;
        exp_mat[10] = p10[15:0];
        exp_mat[11] = p11[15:0];
        exp_mat[14] = 16'h0100;
    endtask

    // One full transaction: accept, latency, result, back-pressure, handshake.
    // While busy, poke drives in_valid with junk operands that must be ignored.
    task automatic run(input logic [15:0] iv, asp, zn, zf, input int hold, input bit poke);
        int lat;
        model(iv, asp, zn, zf);
        @(negedge clk);
        chk("in_ready_idle", 256'(in_ready), 256'(1));
        in_valid = 1; inv_tan = iv; aspect_ratio = asp; z_near = zn; z_far = zf;
        @(posedge clk); #1;
        in_valid = poke;
        inv_tan = 16'($urandom); aspect_ratio = 16'($urandom);
        z_near = 16'($urandom); z_far = 16'($urandom);
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (out_valid) break;
        end
        in_valid = 0;
        chk("latency", 256'(lat), 256'(52));
        chk("matrix", 256'(projection_matrix), 256'(exp_mat));
        chk("div_zero", 256'(div_zero), 256'(m_dz));
        chk("overflow", 256'(overflow), 256'(m_ovf));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_matrix", 256'(projection_matrix), 256'(exp_mat));
            chk("hold_flags", 256'({out_valid, in_ready, div_zero, overflow}),
                256'({1'b1, 1'b0, m_dz, m_ovf}));
        end
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        chk("post_hs", 256'({out_valid, in_ready}), 256'({1'b0, 1'b1}));
        chk("post_matrix", 256'(projection_matrix), 256'(exp_mat));
    endtask

    function automatic logic [15:0] rnd_q();
        logic [15:0] v;
        if ($urandom_range(0, 1) == 1) v = 16'($urandom);
        else begin
            v = 16'($urandom_range(0, 2047));
            if ($urandom_range(0, 1) == 1) v = -v;
        end
        return v;
    endfunction

    initial begin
        logic [15:0] a, b, c, d;
        rst_n = 0; in_valid = 0; out_ready = 0;
        inv_tan = '0; aspect_ratio = '0; z_near = '0; z_far = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", 256'({in_ready, out_valid, div_zero, overflow}), 256'(4'b1000));
        chk("rst_matrix", 256'(projection_matrix), 256'(0));
        @(negedge clk); rst_n = 1;

        // Directed cases with hand-derived results.
        run(16'h0100, 16'h0100, 16'h0100, 16'h0300, 10, 1'b0);
        chk("case1_p10", 256'(projection_matrix[10]), 256'(16'hFE00));
        chk("case1_p11", 256'(projection_matrix[11]), 256'(16'h0300));
        run(16'h0100, 16'hFE00, 16'h0100, 16'h0300, 0, 1'b1);
        chk("neg_asp_p0", 256'(projection_matrix[0]), 256'(16'hFF80));
        run(16'h0100, 16'h0100, 16'h0200, 16'h0200, 2, 1'b0);
        chk("dz_p10", 256'({div_zero, overflow, projection_matrix[10]}), 256'({2'b11, 16'h8000}));
        run(16'h0100, 16'h0100, 16'h6400, 16'h7800, 0, 1'b1);
        chk("sat_p10", 256'({overflow, projection_matrix[10]}), 256'({1'b1, 16'hFA00}));
        run(16'h8000, 16'h0000, 16'h8000, 16'h7FFF, 0, 1'b0);

        // Reset in the middle of DIVK discards the computation.
        @(negedge clk);
        in_valid = 1; inv_tan = 16'h0200; aspect_ratio = 16'h0100;
        z_near = 16'h0100; z_far = 16'h0500;
        @(posedge clk); #1; in_valid = 0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 0;
        @(posedge clk); #1;
        chk("midrst_outputs", 256'({in_ready, out_valid, div_zero, overflow}), 256'(4'b1000));
        chk("midrst_matrix", 256'(projection_matrix), 256'(0));
        @(negedge clk); rst_n = 1;
        run(16'h0200, 16'h0100, 16'h0100, 16'h0500, 1, 1'b0);

        // Randomized operand sets.
        for (int n = 0; n < 24; n++) begin
            a = rnd_q(); b = rnd_q(); c = rnd_q(); d = rnd_q();
            if (n % 8 == 3) d = c;
            if (n % 8 == 5) b = '0;
            run(a, b, c, d, n % 3, 1'(n % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end
endmodule
